crc_pkt_arbiter: RTL and testbench
==================================

CRC_PKT_ARBITER -- requirements
Module: crc_pkt_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one CRC engine; range 2..16.
REQ-002 Parameter DWIDTH, default 512: flit data width in bits; multiple of 8.
REQ-003 Parameter CRC_WIDTH, default 32: width of the CRC result.
REQ-004 Parameter TAG_DEPTH, default 8: maximum number of packets in flight; power of 2.
REQ-005 Port clk, input, 1: clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous, active-high.
REQ-007 Port s_valid, input, N_REQ: per-requester flit valid.
REQ-008 Port s_ready, output, N_REQ: per-requester flit accept.
REQ-009 Port s_data, input, N_REQ*DWIDTH: per-requester flit data; requester i occupies slice i.
REQ-010 Port s_keep, input, N_REQ*DWIDTH/8: per-requester byte enables.
REQ-011 Port s_last, input, N_REQ: per-requester last flit of a packet.
REQ-012 Port eng_din, output, DWIDTH: flit data driven to the CRC engine.
REQ-013 Port eng_byteEn, output, DWIDTH/8: byte enables driven to the engine.
REQ-014 Port eng_dlast, output, 1: last-flit flag driven to the engine.
REQ-015 Port eng_flitEn, output, 1: flit strobe driven to the engine.
REQ-016 Port eng_crc, input, CRC_WIDTH: CRC result from the engine.
REQ-017 Port eng_crc_vld, input, 1: engine result strobe.
REQ-018 Port m_crc, output, CRC_WIDTH: CRC result returned to a requester.
REQ-019 Port m_id, output, clog2(N_REQ): index of the requester that owns m_crc.
REQ-020 Port m_vld, output, 1: one-cycle result strobe; no backpressure.
REQ-021 Port err_orphan, output, 1: sticky flag; set when a result arrives with no tag outstanding.

Function
REQ-022 FSM states: IDLE and BUSY.
REQ-023 IDLE behaviour:
- s_ready is all-zero.
- When any s_valid is set and credits < TAG_DEPTH, the block selects the round-robin winner, registers it as owner, and moves to BUSY on the next cycle.
REQ-024 Round-robin order: search begins at (last owner + 1) mod N_REQ; after reset, search begins at index 0.
REQ-025 BUSY behaviour:
- s_ready[owner] = 1; all other s_ready bits = 0.
- A flit is accepted when s_valid[owner] && s_ready[owner].
REQ-026 Each accepted flit is registered onto eng_* one cycle later, with eng_flitEn = 1 and eng_dlast = s_last[owner].
REQ-027 When no flit is accepted in a cycle, eng_flitEn = 0 and eng_dlast = 0 in the following cycle; eng_din and eng_byteEn hold their values.
REQ-028 Acceptance of a flit with s_last set returns the FSM to IDLE; packets are never interleaved on the engine.
REQ-029 Flits with all-zero keep are forwarded unchanged, including on the last flit.
REQ-030 Credits counter, range 0..TAG_DEPTH:
- +1 on each IDLE-to-BUSY grant.
- -1 on each eng_crc_vld that pops a tag.
- Simultaneous +1 and -1 leave it unchanged.
REQ-031 Tag FIFO, depth TAG_DEPTH, holds owner indices:
- Push the owner index on acceptance of each last flit.
- Pop on eng_crc_vld.
- A push and a pop in the same cycle are both honoured.
- The FIFO never overflows, because credits gate new grants.
REQ-032 On eng_crc_vld with the FIFO non-empty, the next cycle drives m_vld = 1, m_crc = eng_crc, and m_id = the popped tag.
REQ-033 On eng_crc_vld with the FIFO empty:
- m_vld stays 0.
- err_orphan is set and stays set until rst.
- Credits are unchanged.
REQ-034 When credits == TAG_DEPTH, no new grant is made; a packet already in BUSY completes normally.
REQ-035 The engine must use the same clk and rst as this block; the engine's results return in dlast order, so FIFO order equals result order.

Reset
REQ-036 While rst is high, at the next edge:
- FSM goes to IDLE; credits = 0; FIFO is empty; round-robin pointer is at index 0.
- s_ready = 0, eng_flitEn = 0, eng_dlast = 0, eng_din = 0, eng_byteEn = 0.
- m_vld = 0, m_crc = 0, m_id = 0, err_orphan = 0.
REQ-037 A reset asserted mid-packet abandons the packet: no tag is pushed and no result is emitted for it.

Verification
REQ-038 Single requester:
- Stimulus: requester 2 sends a 3-flit packet with s_valid held high.
- Response: grant in cycle 1; s_ready[2] high for cycles 2-4; eng_flitEn high in cycles 3-5 with eng_dlast only in cycle 5.
- Response: when the engine result arrives, m_vld = 1 with m_id = 2.
REQ-039 Contention:
- Stimulus: requesters 0-3 all hold 1-flit packets valid from reset.
- Response: grant order is 0,1,2,3,0.
- Response: m_id values come back in the same order.
REQ-040 Credit stall:
- Stimulus: TAG_DEPTH = 2; the engine result is withheld while three packets are offered.
- Response: the third grant waits until the first eng_crc_vld arrives.
REQ-041 Simultaneous events:
- Stimulus: a last-flit push and an eng_crc_vld pop occur in the same cycle.
- Response: FIFO occupancy and credits are unchanged, and the correct m_id is emitted.
REQ-042 Orphan result:
- Stimulus: eng_crc_vld is pulsed with the FIFO empty.
- Response: m_vld stays 0 and err_orphan = 1 until rst.
REQ-043 Reset mid-packet:
- Stimulus: rst asserted during flit 2 of a 4-flit packet.
- Response: all outputs take their REQ-036 values.
- Response: the next packet from requester 0 is granted first.

Source files
------------

// File: rtl/crc_pkt_arbiter.sv
// rtl/crc_pkt_arbiter.sv - round-robin packet arbiter in front of one shared CRC engine
module crc_pkt_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 512,
  parameter int CRC_WIDTH = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            s_valid_i,
  output logic [N_REQ-1:0]            s_ready_o,
  input  logic [N_REQ*DWIDTH-1:0]     s_data_i,
  input  logic [N_REQ*DWIDTH/8-1:0]   s_keep_i,
  input  logic [N_REQ-1:0]            s_last_i,
  output logic [DWIDTH-1:0]           eng_din_o,
  output logic [DWIDTH/8-1:0]         eng_byteEn_o,
  output logic                        eng_dlast_o,
  output logic                        eng_flitEn_o,
  input  logic [CRC_WIDTH-1:0]        eng_crc_i,
  input  logic                        eng_crc_vld_i,
  output logic [CRC_WIDTH-1:0]        m_crc_o,
  output logic [$clog2(N_REQ)-1:0]    m_id_o,
  output logic                        m_vld_o,
  output logic                        err_orphan_o
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int IDW1 = IDW + 1;
  localparam int KW   = DWIDTH / 8;
  localparam int AW   = $clog2(TAG_DEPTH);
  localparam int CW   = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, rr_ptr_q;
  logic [CW-1:0]     credits_q, count_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [IDW-1:0]    tag_mem [TAG_DEPTH];
  logic [DWIDTH-1:0] eng_din_q;
  logic [KW-1:0]     eng_byteen_q;
  logic              eng_dlast_q, eng_flit_q;
  logic [CRC_WIDTH-1:0] m_crc_q;
  logic [IDW-1:0]    m_id_q;
  logic              m_vld_q, err_orphan_q;

  logic              win_found;
  logic [IDW-1:0]    win_idx, cand;
  logic [IDW1-1:0]   sum;
  logic [DWIDTH-1:0] sel_data;
  logic [KW-1:0]     sel_keep;
  logic              sel_valid, sel_last;
  logic              grant, accept, last_acc, fifo_empty, pop, push;

  // Round-robin search starting at the slot after the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + IDW1'(k);
      if (sum >= IDW1'(N_REQ)) sum = sum - IDW1'(N_REQ);
      cand = sum[IDW-1:0];
      if (!win_found && s_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Steer the owner's flit lanes onto a single set of signals.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        sel_data  = s_data_i[i*DWIDTH +: DWIDTH];
        sel_keep  = s_keep_i[i*KW +: KW];
        sel_valid = s_valid_i[i];
        sel_last  = s_last_i[i];
      end
    end
  end

  // A grant needs a free tag slot; credits count grants not yet answered.
  assign grant      = (state_q == IDLE) && win_found && (credits_q < CW'(TAG_DEPTH));
  assign accept     = (state_q == BUSY) && sel_valid;
  assign last_acc   = accept && sel_last;
  assign fifo_empty = (count_q == '0);
  assign pop        = eng_crc_vld_i && !fifo_empty;
  assign push       = last_acc;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one whole packet per grant, never interleaved.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (last_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the current owner sees ready, and only while BUSY.
  always_comb begin
    s_ready_o = '0;
    if (state_q == BUSY) s_ready_o[owner_q] = 1'b1;
  end

  // Owner capture and round-robin pointer advance on each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (grant) begin
      owner_q  <= win_idx;
      rr_ptr_q <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Credits: up on grant, down on an answered result; both at once cancel.
  always_ff @(posedge clk) begin
    if (rst) credits_q <= '0;
    else begin
      case ({grant, pop})
        2'b10:   credits_q <= credits_q + 1'b1;
        2'b01:   credits_q <= credits_q - 1'b1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; results come back in dlast order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage holds the owner index of every packet awaiting its CRC.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= owner_q;
  end

  // Engine-side flit register; data lanes hold when no flit is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_din_q    <= '0;
      eng_byteen_q <= '0;
      eng_flit_q   <= 1'b0;
      eng_dlast_q  <= 1'b0;
    end else begin
      eng_flit_q  <= accept;
      eng_dlast_q <= last_acc;
      if (accept) begin
        eng_din_q    <= sel_data;
        eng_byteen_q <= sel_keep;
      end
    end
  end

  // Result return path and sticky flag for results nobody asked for.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q      <= 1'b0;
      m_crc_q      <= '0;
      m_id_q       <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      m_vld_q <= pop;
      if (pop) begin
        m_crc_q <= eng_crc_i;
        m_id_q  <= tag_mem[rd_ptr_q];
      end
      if (eng_crc_vld_i && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  assign eng_din_o    = eng_din_q;
  assign eng_byteEn_o = eng_byteen_q;
  assign eng_dlast_o  = eng_dlast_q;
  assign eng_flitEn_o = eng_flit_q;
  assign m_crc_o      = m_crc_q;
  assign m_id_o       = m_id_q;
  assign m_vld_o      = m_vld_q;
  assign err_orphan_o = err_orphan_q;

endmodule

// File: tb/tb_crc_pkt_arbiter.sv
// tb/tb_crc_pkt_arbiter.sv - self-checking bench for crc_pkt_arbiter
module tb_crc_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int CW = 32;
  localparam int TD = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_valid = '0, s_last = '0, s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic [N*KW-1:0] s_keep = '0;
  logic [DW-1:0]   eng_din;
  logic [KW-1:0]   eng_byteEn;
  logic            eng_dlast, eng_flitEn;
  logic [CW-1:0]   eng_crc = '0;
  logic            eng_crc_vld = 1'b0;
  logic [CW-1:0]   m_crc;
  logic [1:0]      m_id;
  logic            m_vld, err_orphan;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // reference model state
  bit              md_busy = 1'b0;
  int              md_owner = 0, md_last = -1, md_credits = 0;
  int              tagq[$];
  bit              e_flit = 1'b0, e_dlast = 1'b0, e_mvld = 1'b0, e_orph = 1'b0;
  logic [DW-1:0]   e_din = '0;
  logic [KW-1:0]   e_keep = '0;
  logic [CW-1:0]   e_mcrc = '0;
  int              e_mid = 0;

  int              glog[$], rlog[$];
  logic [N-1:0]    prev_rdy = '0;
  int              pending = 0;
  int              g0, r0;
  int              exp_g[5] = '{0, 1, 2, 3, 0};
  int              exp_r[4] = '{0, 1, 2, 3};

  crc_pkt_arbiter #(.N_REQ(N), .DWIDTH(DW), .CRC_WIDTH(CW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_keep_i(s_keep),
    .s_last_i(s_last),
    .eng_din_o(eng_din), .eng_byteEn_o(eng_byteEn), .eng_dlast_o(eng_dlast),
    .eng_flitEn_o(eng_flitEn), .eng_crc_i(eng_crc), .eng_crc_vld_i(eng_crc_vld),
    .m_crc_o(m_crc), .m_id_o(m_id), .m_vld_o(m_vld), .err_orphan_o(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock from the inputs currently applied.
  task automatic model_step();
    bit acc, lst, gnt;
    int w;
    if (rst) begin
      md_busy = 1'b0; md_owner = 0; md_last = -1; md_credits = 0; tagq.delete();
      e_flit = 1'b0; e_dlast = 1'b0; e_din = '0; e_keep = '0;
      e_mvld = 1'b0; e_mcrc = '0; e_mid = 0; e_orph = 1'b0;
    end else begin
      acc = md_busy && s_valid[md_owner];
      lst = acc && s_last[md_owner];
      gnt = 1'b0;
      w   = 0;
      if (!md_busy && md_credits < TD) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (md_last + k) % N;
          if (!gnt && s_valid[i]) begin gnt = 1'b1; w = i; end
        end
      end
      e_mvld = 1'b0;
      if (eng_crc_vld) begin
        if (tagq.size() == 0) e_orph = 1'b1;
        else begin
          e_mvld = 1'b1;
          e_mid  = tagq.pop_front();
          e_mcrc = eng_crc;
          md_credits--;
        end
      end
      e_flit  = acc;
      e_dlast = lst;
      if (acc) begin
        e_din  = s_data[md_owner*DW +: DW];
        e_keep = s_keep[md_owner*KW +: KW];
      end
      if (lst) begin tagq.push_back(md_owner); md_busy = 1'b0; end
      if (gnt) begin md_busy = 1'b1; md_owner = w; md_last = w; md_credits++; end
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", s_ready, md_busy ? (64'd1 << md_owner) : 64'd0);
      chk("eng_flitEn", eng_flitEn, e_flit);
      chk("eng_dlast", eng_dlast, e_dlast);
      chk("eng_din", eng_din, e_din);
      chk("eng_byteEn", eng_byteEn, e_keep);
      chk("m_vld", m_vld, e_mvld);
      chk("err_orphan", err_orphan, e_orph);
      if (e_mvld) begin
        chk("m_crc", m_crc, e_mcrc);
        chk("m_id", m_id, e_mid);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    if (prev_rdy == '0 && s_ready != '0)
      for (int i = 0; i < N; i++) if (s_ready[i]) glog.push_back(i);
    prev_rdy = s_ready;
    if (m_vld) rlog.push_back(int'(m_id));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eng_crc_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    pending = 0;
  endtask

  // Engine stand-in: answers each observed dlast in order after a random delay.
  task automatic engine_step();
    if (eng_flitEn && eng_dlast) pending++;
    eng_crc_vld = 1'b0;
    if (pending > 0 && $urandom_range(0, 1) == 1) begin
      eng_crc_vld = 1'b1;
      eng_crc     = $urandom;
      pending--;
    end
  endtask

  task automatic run_auto(int n, bit rnd);
    for (int c = 0; c < n; c++) begin
      engine_step();
      if (rnd) begin
        rst = ($urandom_range(0, 399) == 0);
        if (rst) begin pending = 0; eng_crc_vld = 1'b0; end
        for (int i = 0; i < N; i++) begin
          s_valid[i] = ($urandom_range(0, 9) < 7);
          s_last[i]  = ($urandom_range(0, 2) == 0);
          s_data[i*DW +: DW] = $urandom;
          s_keep[i*KW +: KW] = KW'($urandom_range(0, 15));
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_flitEn", eng_flitEn, 0);
    chk("rst_dlast", eng_dlast, 0);
    chk("rst_din", eng_din, 0);
    chk("rst_byteEn", eng_byteEn, 0);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_crc", m_crc, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_err", err_orphan, 0);

    // single requester, 3-flit packet, last flit with empty keep
    s_valid = 4'b0100; s_data[2*DW +: DW] = 32'hA0A0_0000; s_keep[2*KW +: KW] = 4'hF;
    tick();
    chk("a_ready_c2", s_ready, 4'b0100);
    chk("a_flit_c2", eng_flitEn, 0);
    tick();
    chk("a_ready_c3", s_ready, 4'b0100);
    chk("a_flit_c3", eng_flitEn, 1);
    chk("a_dlast_c3", eng_dlast, 0);
    chk("a_din_c3", eng_din, 32'hA0A0_0000);
    s_data[2*DW +: DW] = 32'hA0A0_0001;
    tick();
    chk("a_ready_c4", s_ready, 4'b0100);
    chk("a_din_c4", eng_din, 32'hA0A0_0001);
    s_data[2*DW +: DW] = 32'hA0A0_0002; s_keep[2*KW +: KW] = 4'h0; s_last[2] = 1'b1;
    tick();
    chk("a_ready_c5", s_ready, 0);
    chk("a_flit_c5", eng_flitEn, 1);
    chk("a_dlast_c5", eng_dlast, 1);
    chk("a_din_c5", eng_din, 32'hA0A0_0002);
    chk("a_keep_c5", eng_byteEn, 0);
    s_valid = '0; s_last = '0;
    tick();
    chk("a_flit_c6", eng_flitEn, 0);
    chk("a_din_hold", eng_din, 32'hA0A0_0002);
    eng_crc = 32'hC0FF_EE02; eng_crc_vld = 1'b1;
    tick();
    eng_crc_vld = 1'b0;
    chk("a_m_vld", m_vld, 1);
    chk("a_m_id", m_id, 2);
    chk("a_m_crc", m_crc, 32'hC0FF_EE02);
    tick();
    chk("a_m_vld_pulse", m_vld, 0);

    // contention: all four hold 1-flit packets from reset
    s_valid = 4'b1111; s_last = 4'b1111;
    rst = 1'b1; tick(); rst = 1'b0; pending = 0;
    g0 = glog.size(); r0 = rlog.size();
    run_auto(80, 1'b0);
    chk("cont_ngrants", (glog.size() - g0) >= 5, 1);
    chk("cont_nresults", (rlog.size() - r0) >= 4, 1);
    for (int k = 0; k < 5; k++) if (glog.size() > g0 + k) chk("cont_grant", glog[g0+k], exp_g[k]);
    for (int k = 0; k < 4; k++) if (rlog.size() > r0 + k) chk("cont_mid", rlog[r0+k], exp_r[k]);

    // credit stall with results withheld
    s_valid = '0; s_last = '0;
    do_reset();
    s_valid = 4'b0010; s_last = 4'b0010;
    g0 = glog.size();
    repeat (20) tick();
    chk("stall_grants", glog.size() - g0, 2);
    eng_crc = 32'h5EED_0001; eng_crc_vld = 1'b1;
    tick();
    eng_crc_vld = 1'b0;
    chk("stall_wait", glog.size() - g0, 2);
    chk("stall_m_vld", m_vld, 1);
    chk("stall_m_id", m_id, 1);
    tick();
    chk("stall_third", glog.size() - g0, 3);

    // push and pop in the same cycle, then an orphan result
    s_valid = '0; s_last = '0;
    do_reset();
    s_valid = 4'b1000; s_last = 4'b1000;
    tick();
    tick();
    s_valid = 4'b0010; s_last = '0;
    tick();
    chk("sim_ready", s_ready, 4'b0010);
    tick();
    s_last = 4'b0010; eng_crc = 32'h0000_0033; eng_crc_vld = 1'b1;
    tick();
    chk("sim_m_vld", m_vld, 1);
    chk("sim_m_id", m_id, 3);
    chk("sim_dlast", eng_dlast, 1);
    s_valid = '0; s_last = '0; eng_crc_vld = 1'b0;
    tick();
    eng_crc = 32'h0000_0011; eng_crc_vld = 1'b1;
    tick();
    chk("sim2_m_vld", m_vld, 1);
    chk("sim2_m_id", m_id, 1);
    chk("sim2_err", err_orphan, 0);
    tick();
    eng_crc_vld = 1'b0;
    chk("orph_m_vld", m_vld, 0);
    chk("orph_err", err_orphan, 1);
    repeat (5) tick();
    chk("orph_sticky", err_orphan, 1);
    do_reset();
    chk("orph_cleared", err_orphan, 0);

    // reset in the middle of a packet
    s_valid = 4'b0010; s_last = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", s_ready, 0);
    chk("mid_flit", eng_flitEn, 0);
    chk("mid_din", eng_din, 0);
    chk("mid_keep", eng_byteEn, 0);
    chk("mid_m_vld", m_vld, 0);
    s_valid = 4'b1001; s_last = 4'b1001;
    tick();
    chk("mid_regrant", s_ready, 4'b0001);

    // randomized traffic with an in-order engine and rare resets
    s_valid = '0; s_last = '0;
    do_reset();
    run_auto(3000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
